// File: rtl/ps2_key_encoder_if.sv
// -----------------------------------------------------------------------------
// ps2_key_encoder_if
// Groups the PS/2 pin inputs and the key-event outputs of ps2_key_encoder.
//   ps2_clk   : raw PS/2 clock, idle high (driven by master)
//   ps2_data  : raw PS/2 data, idle high (driven by master)
//   ps2_key   : {toggle, pressed, extended, code[7:0]} (driven by slave)
//   frame_err : one-cycle pulse on parity/stop/timeout error (driven by slave)
//   busy      : high while a frame is being received (driven by slave)
// The master modport is the keyboard side plus key consumer; the slave modport
// is the encoder itself.
// -----------------------------------------------------------------------------
interface ps2_key_encoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, frame_err, busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, frame_err, busy
  );
endinterface

// File: rtl/ps2_key_encoder.sv
// -----------------------------------------------------------------------------
// ps2_key_encoder
// Deserialises raw PS/2 keyboard frames and produces the 11-bit ps2_key event
// word {toggle, pressed, extended, code}. Bit 10 toggles once per key event.
// Ports:
//   clk_sys : system clock, the only clock
//   reset   : asynchronous, active-high reset
//   bus     : ps2_key_encoder_if.slave (ps2_clk/ps2_data in,
//             ps2_key/frame_err/busy out)
// Parameters:
//   FILTER      : consecutive equal samples before the filtered clock changes
//   TIMEOUT_CYC : cycles without a falling edge before a frame is aborted
// -----------------------------------------------------------------------------
module ps2_key_encoder #(
  parameter int FILTER      = 8,
  parameter int TIMEOUT_CYC = 2400
) (
  input  logic               clk_sys,
  input  logic               reset,
  ps2_key_encoder_if.slave   bus
);

  localparam int FLT_W = $clog2(FILTER + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  // Synchronisers, glitch filter and edge detect
  logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic             r_filt;
  logic [FLT_W-1:0] r_filt_cnt;
  logic             r_fall;

  // Receiver
  state_t           r_state, w_state_nxt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic [TO_W-1:0]  r_to_cnt;
  logic             w_frame_done, w_timeout, w_byte_ok;

  // Decoder
  logic             r_ext, r_rel;
  logic [2:0]       r_skip;
  logic [10:0]      r_ps2_key;
  logic             r_frame_err;

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, whatever block order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 != r_filt) begin
        // FILTER-th consecutive differing sample: commit the new level.
        if (r_filt_cnt == FLT_LAST) begin
          r_filt     <= r_clk_s2;
          r_filt_cnt <= '0;
          r_fall     <= r_filt;   // only a 1->0 change is an edge event
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_fall && !r_dat_s2) w_state_nxt = S_RECV;
      end
      S_RECV: begin
        if (r_fall && r_bit_cnt == 4'd9) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
        end else if (!r_fall && r_to_cnt == TO_LAST) begin
          // An edge in the limit cycle takes priority over the abort.
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stop bit is the live sample; odd parity over data plus parity bit.
  assign w_byte_ok = r_dat_s2 & (^{r_shift, r_par});

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_fall || r_state != S_RECV) r_to_cnt <= '0;
      else                             r_to_cnt <= r_to_cnt + 1'b1;

      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
      end else if (r_fall) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_bit_cnt < 4'd8)       r_shift <= {r_dat_s2, r_shift[7:1]};
        else if (r_bit_cnt == 4'd8) r_par   <= r_dat_s2;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ext       <= 1'b0;
      r_rel       <= 1'b0;
      r_skip      <= '0;
      r_ps2_key   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_timeout) begin
        r_frame_err <= 1'b1;         // prefix flags survive a timeout
      end else if (w_frame_done) begin
        if (!w_byte_ok) begin
          r_frame_err <= 1'b1;
          r_ext       <= 1'b0;
          r_rel       <= 1'b0;
        end else if (r_skip != '0) begin
          r_skip <= r_skip - 1'b1;   // remainder of the Pause sequence
        end else begin
          case (r_shift)
            8'hE0: r_ext  <= 1'b1;
            8'hF0: r_rel  <= 1'b1;
            8'hE1: r_skip <= 3'd7;
            8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
              // device status bytes: ignored, flags untouched
            end
            default: begin
              r_ps2_key <= {~r_ps2_key[10], ~r_rel, r_ext, r_shift};
              r_ext     <= 1'b0;
              r_rel     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.ps2_key   = r_ps2_key;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state == S_RECV);

endmodule

// File: doc/ps2_key_encoder.md
# ps2_key_encoder

Deserialises raw PS/2 keyboard traffic and produces the 11-bit `ps2_key` event word consumed by arcade cores' key decoders. It is the producer end of that interface: `[10]` toggles once per key event, `[9]` is the pressed flag, `[8]` the extended flag and `[7:0]` the scan code. It sits between the PS/2 pins (or a USB-to-PS/2 bridge) and the core's `ps2_key` input, in the `clk_sys` domain.

## Interface
Parameters:
- `FILTER`, 8: consecutive equal samples required before filtered `ps2_clk` changes state.
- `TIMEOUT_CYC`, 2400: `clk_sys` cycles with no filtered falling edge before an in-progress frame is aborted (100 µs at 24 MHz).

Ports:
- `clk_sys  in  1`: system clock; the only clock.
- `reset  in  1`: asynchronous, active-high reset.
- `ps2_clk  in  1`: raw PS/2 clock, asynchronous, idle high.
- `ps2_data  in  1`: raw PS/2 data, asynchronous, idle high.
- `ps2_key  out  11`: event word `{toggle, pressed, extended, code[7:0]}`.
- `frame_err  out  1`: one-cycle pulse on a parity, stop-bit or timeout error.
- `busy  out  1`: high while a frame is being received.

## Operation
- Both pins pass through 2-flop synchronisers, reset to 1.
- The filtered clock changes only after `FILTER` consecutive synchronised samples differ from its current value. A filtered 1→0 transition is an edge event; `ps2_data` (synchronised) is sampled in that cycle.
- Frames are 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- Receiver FSM:
  - IDLE: on an edge with data=0, go to RECV, clear the bit counter, raise `busy`. On an edge with data=1, stay in IDLE; this is not an error.
  - RECV: shift the data bits and capture parity. The stop bit is the 10th edge after start. Then go to IDLE and drop `busy`.
  - If parity is not odd or stop=0: pulse `frame_err`, discard the byte, clear the prefix flags.
- Timeout counter:
  - Cleared on every edge; counts only in RECV.
  - Reaching `TIMEOUT_CYC-1` returns the FSM to IDLE and pulses `frame_err`. Prefix flags are kept.
  - If an edge arrives in the same cycle the limit is reached, the edge wins and there is no abort.
- Byte decoder, for each good byte:
  - `E0`: set `ext`, no event.
  - `F0`: set `rel`, no event.
  - `E1`: discard it and the next 7 good bytes (Pause sequence). No event; flags untouched.
  - `AA`, `FA`, `EE`, `FE` (device status): discard, flags untouched.
  - Any other byte b: `ps2_key <= {~ps2_key[10], ~rel, ext, b}` in one register update, then clear `ext` and `rel`.
- Reset, including mid-frame: `ps2_key`=0, `frame_err`=0, `busy`=0, FSM=IDLE, flags and skip count cleared, filter state=1. A partial frame is abandoned with no event and no error.

## Timing
- `ps2_key` and `frame_err` register in the cycle after the filtered stop-bit edge. That is 3+`FILTER` cycles after the raw 11th falling edge; benches allow ±1 for sampling phase.
- `busy` rises the cycle after the filtered start edge and falls in the same cycle `ps2_key` updates. On abort it falls in the cycle `frame_err` pulses.
- All `ps2_key` bits change in the same cycle.
- At most one toggle per frame. Events are never dropped at PS/2 rates: the minimum frame spacing is far more than 1 cycle.
- PS/2 bit period of 60–100 µs; `FILTER`+2 must be less than half of it.

## Test plan
- After reset, send frame `0x1C` with parity 0 and stop 1 → `ps2_key` goes 0x000 → 0x61C exactly once; `frame_err` stays 0; `busy` is high only during the frame.
- Send `E0`, `F0`, `75` → no change after the first two frames; after the third `ps2_key`=0x175 (toggle back to 0). A following `75` gives 0x6?? pattern `{1,1,0,0x75}`=0x675.
- Send `0x29` with the parity bit inverted → one-cycle `frame_err`, `ps2_key` unchanged. A valid `0x29` next → toggle flips, `[9:0]`=0x229.
- Send start + 4 data bits, then hold `ps2_clk` high for 2×`TIMEOUT_CYC` → exactly one `frame_err`, `busy` returns to 0. A full `0x05` frame next → `{t,1,0,0x05}`.
- Send the Pause sequence `E1 14 77 E1 F0 14 F0 77`, then `06` → a single toggle, with `[9:0]`=0x206. Also send `AA` → no event.
- While idle, pulse `ps2_clk` low for `FILTER`-2 cycles → no `busy`, no event. Assert `reset` after bit 5 of a frame → outputs 0 asynchronously; the next full frame decodes correctly.
